if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage ARM pipeline.
- Holds the PC and drives the word address into the combinational instruction memory (1 KB, 256 words, read via addr[31:2]).
- Registers the fetched word into the IF/ID pipeline register for the decode stage.
- Handles hazard freeze, branch redirect/flush, an out-of-range fetch flag and a fetch counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 256, instruction-memory depth in 32-bit words; used for out-of-range detection.
- NOP_INST, 32'h0000_0000, word placed in IF/ID on reset or flush (bubble).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- freeze  in  1  hazard-unit stall; holds PC and IF/ID.
- branch_taken  in  1  redirect from EXE; flushes IF/ID.
- branch_addr  in  32  branch target byte address.
- imem_addr  out  32  byte address to instruction memory (= pc).
- imem_inst  in  32  instruction word from memory, combinational from imem_addr.
- id_pc  out  32  registered PC+4 of the instruction in IF/ID.
- id_inst  out  32  registered instruction.
- id_valid  out  1  IF/ID holds a real instruction.
- id_fault  out  1  registered instruction was fetched from beyond IMEM_WORDS.
- fetch_count  out  32  number of instructions delivered to IF/ID.

Behaviour:
- All state updates on the rising edge of clk. Reset is sampled on the edge only; there is no asynchronous path.
- Reset (rst_n=0) has priority over every other input:
  - pc=RESET_PC
  - id_pc=0, id_inst=NOP_INST, id_valid=0, id_fault=0
  - fetch_count=0
- A reset asserted mid-operation discards any pending branch or freeze that cycle.
- imem_addr = pc, combinational. The memory returns the word in the same cycle.
- pc_next = pc + 4, 32-bit modulo. 32'hFFFF_FFFC wraps to 0.
- PC update priority (rst_n=1):
  - branch_taken=1: pc <= {branch_addr[31:2],2'b00}. Low two bits are ignored.
  - else freeze=1: pc holds.
  - else: pc <= pc_next.
- IF/ID update priority (rst_n=1):
  - branch_taken=1 (flush): id_inst<=NOP_INST, id_pc<=0, id_valid<=0, id_fault<=0. This holds even if freeze=1.
  - else freeze=1: all IF/ID fields hold.
  - else: id_inst<=imem_inst, id_pc<=pc_next, id_valid<=1, id_fault<=(pc[31:2] >= IMEM_WORDS).
- branch_taken and freeze asserted together: branch wins on both the PC and IF/ID.
- fetch_count increments by 1 exactly on edges where IF/ID loads a new valid instruction (rst_n=1, branch_taken=0, freeze=0). It wraps at 2^32.
- Latency:
  - An instruction at address A appears on id_inst one edge after pc=A with freeze=0.
  - A branch takes effect on the next edge: the target word appears in IF/ID two edges after branch_taken.
  - Exactly one bubble is inserted by this stage.
- The fault is only flagged; fetch continues. Downstream decides whether to act on id_fault.
- There is no combinational path from any input to an id_* output.

Decomposition:
- Shared ARM package holds:
  - constants WORD_BYTES=4, RESET_PC default, NOP_INST.
  - IMEM_WORDS=256 (shared with instruction memory).
  - a packed IF/ID struct type {pc, inst, valid, fault}.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with freeze/flush/reset priority.
- PC register, adder and counter stay in if_stage.

Test Plan:
- Reset then release with freeze=0 and memory preloaded with the standard test program:
  - cycle 0: imem_addr=0.
  - after edge 1: id_inst=32'hE3A00014, id_pc=4, id_valid=1, fetch_count=1.
  - after edge 2: imem_addr=8.
- Freeze held 3 cycles at pc=12:
  - imem_addr stays 12; id_inst/id_pc/id_valid unchanged; fetch_count unchanged.
  - Release: next edge loads word 3 with id_pc=16.
- branch_taken=1, branch_addr=32'h0000_0076 while pc=152:
  - next edge: pc=32'h74, id_valid=0, id_inst=NOP_INST.
  - following edge: id_pc=32'h78, id_valid=1.
- branch_taken=1 and freeze=1 in the same cycle: PC still redirects and IF/ID is flushed (id_valid=0).
- Force pc to 32'h400 via branch, then run 2 cycles:
  - id_fault=1 for the instruction from 32'h400.
  - PC keeps advancing to 32'h404, then 32'h408.
- Assert rst_n=0 mid-run during freeze with branch_taken=1: after the edge, pc=RESET_PC, id_valid=0, fetch_count=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared ARM pipeline constants and the IF/ID pipeline register layout.
package if_stage_pkg;
  localparam int unsigned WORD_BYTES   = 4;
  localparam int unsigned IMEM_WORDS   = 256;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        fault;
  } if_id_t;
endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: reset beats flush, flush beats freeze, freeze beats load.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_INST
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_freeze,
  input  logic   i_flush,
  input  if_id_t i_d,
  output if_id_t o_q
);
  if_id_t w_bubble;
  if_id_t r_q;

  assign w_bubble = '{pc: 32'h0, inst: NOP_WORD, valid: 1'b0, fault: 1'b0};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)      r_q <= w_bubble;
    else if (i_flush)  r_q <= w_bubble;
    else if (!i_freeze) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, sequential adder, branch redirect and fetch counter.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int unsigned IMEM_WORDS = if_stage_pkg::IMEM_WORDS,
  parameter logic [31:0] NOP_INST   = if_stage_pkg::NOP_INST
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_freeze,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_addr,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_inst,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_inst,
  output logic        o_id_valid,
  output logic        o_id_fault,
  output logic [31:0] o_fetch_count
);
  logic [31:0] r_pc;
  logic [31:0] r_fetch_count;
  logic [31:0] w_pc_next;
  logic        w_fault;
  logic        w_load;
  if_id_t      w_d;
  if_id_t      w_q;

  assign w_pc_next = r_pc + 32'(WORD_BYTES);
  // Word index beyond the memory depth; the high bits are never aliased away.
  assign w_fault   = ({2'b00, r_pc[31:2]} >= 32'(IMEM_WORDS));
  assign w_load    = !i_branch_taken && !i_freeze;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc          <= RESET_PC;
      r_fetch_count <= 32'h0;
    end else begin
      if (i_branch_taken) r_pc <= {i_branch_addr[31:2], 2'b00};
      else if (!i_freeze) r_pc <= w_pc_next;
      if (w_load) r_fetch_count <= r_fetch_count + 32'h1;
    end
  end

  assign w_d = '{pc: w_pc_next, inst: i_imem_inst, valid: 1'b1, fault: w_fault};

  if_id_reg #(.NOP_WORD(NOP_INST)) u_if_id (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_freeze(i_freeze),
    .i_flush (i_branch_taken),
    .i_d     (w_d),
    .o_q     (w_q)
  );

  assign o_imem_addr   = r_pc;
  assign o_id_pc       = w_q.pc;
  assign o_id_inst     = w_q.inst;
  assign o_id_valid    = w_q.valid;
  assign o_id_fault    = w_q.fault;
  assign o_fetch_count = r_fetch_count;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random freeze/branch traffic against a fetch model.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, freeze, branch_taken;
  logic [31:0] branch_addr, imem_addr, imem_inst, id_pc, id_inst, fetch_count;
  logic        id_valid, id_fault;

  logic [31:0] mem [256];
  int errors = 0;
  int checks = 0;

  // Model of architectural state.
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_cnt;
  logic        m_id_valid, m_id_fault;

  always #5 clk = ~clk;

  // Memory is 1 KB, so higher addresses alias onto it.
  assign imem_inst = mem[imem_addr[9:2]];

  if_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_freeze(freeze), .i_branch_taken(branch_taken),
    .i_branch_addr(branch_addr), .o_imem_addr(imem_addr), .i_imem_inst(imem_inst),
    .o_id_pc(id_pc), .o_id_inst(id_inst), .o_id_valid(id_valid), .o_id_fault(id_fault),
    .o_fetch_count(fetch_count)
  );

  // Drive one cycle, let the edge happen, advance the model, sample 1 ns later.
  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] ba);
    @(negedge clk);
    rst_n = r; freeze = f; branch_taken = b; branch_addr = ba;
    @(posedge clk);
    if (!r) begin
      m_pc = 32'h0; m_id_pc = 0; m_id_inst = NOP; m_id_valid = 0; m_id_fault = 0; m_cnt = 0;
    end else if (b) begin
      m_pc = ba & ~32'h3; m_id_pc = 0; m_id_inst = NOP; m_id_valid = 0; m_id_fault = 0;
    end else if (!f) begin
      m_id_inst  = mem[m_pc[9:2]];
      m_id_pc    = m_pc + 32'd4;
      m_id_valid = 1;
      m_id_fault = (m_pc >= 32'd1024);
      m_cnt      = m_cnt + 1;
      m_pc       = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 1, 1, 32'h40);
    step(0, 0, 0, 0);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
    checks++; if (id_inst !== NOP || id_pc !== 0 || id_fault !== 0) begin errors++;
      $display("FAIL reset_ifid inst=%h pc=%h fault=%b exp NOP/0/0", id_inst, id_pc, id_fault); end
    checks++; if (fetch_count !== 0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
  endtask

  task automatic test_startup();
    step(1, 0, 0, 0);
    checks++; if (id_inst !== 32'hE3A00014 || id_pc !== 32'd4 || id_valid !== 1'b1) begin errors++;
      $display("FAIL first_fetch inst=%h pc=%h v=%b exp E3A00014/4/1", id_inst, id_pc, id_valid); end
    checks++; if (fetch_count !== 1) begin errors++; $display("FAIL first_count got=%0d exp=1", fetch_count); end
    step(1, 0, 0, 0);
    checks++; if (imem_addr !== 32'd8) begin errors++; $display("FAIL second_addr got=%h exp=8", imem_addr); end
  endtask

  task automatic test_freeze();
    step(1, 0, 0, 0); // pc now 12
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      checks++; if (imem_addr !== 32'd12 || id_pc !== 32'd12 || id_inst !== mem[2] || id_valid !== 1'b1) begin errors++;
        $display("FAIL freeze_hold addr=%h idpc=%h inst=%h v=%b", imem_addr, id_pc, id_inst, id_valid); end
      checks++; if (fetch_count !== 3) begin errors++; $display("FAIL freeze_count got=%0d exp=3", fetch_count); end
    end
    step(1, 0, 0, 0);
    checks++; if (id_inst !== mem[3] || id_pc !== 32'd16) begin errors++;
      $display("FAIL freeze_release inst=%h pc=%h exp %h/16", id_inst, id_pc, mem[3]); end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 100 && m_pc != 32'd152; i++) step(1, 0, 0, 0);
    checks++; if (imem_addr !== 32'd152) begin errors++; $display("FAIL reach_152 got=%h", imem_addr); end
    step(1, 0, 1, 32'h0000_0076);
    checks++; if (imem_addr !== 32'h74 || id_valid !== 1'b0 || id_inst !== NOP) begin errors++;
      $display("FAIL branch_redirect addr=%h v=%b inst=%h exp 74/0/NOP", imem_addr, id_valid, id_inst); end
    step(1, 0, 0, 0);
    checks++; if (id_pc !== 32'h78 || id_valid !== 1'b1 || id_inst !== mem[29]) begin errors++;
      $display("FAIL branch_target pc=%h v=%b inst=%h exp 78/1/%h", id_pc, id_valid, id_inst, mem[29]); end
  endtask

  task automatic test_branch_freeze();
    step(1, 1, 1, 32'h0000_0020);
    checks++; if (imem_addr !== 32'h20 || id_valid !== 1'b0) begin errors++;
      $display("FAIL branch_and_freeze addr=%h v=%b exp 20/0", imem_addr, id_valid); end
  endtask

  task automatic test_fault();
    step(1, 0, 1, 32'h0000_0400);
    step(1, 0, 0, 0);
    checks++; if (id_fault !== 1'b1 || imem_addr !== 32'h404) begin errors++;
      $display("FAIL fault_first fault=%b addr=%h exp 1/404", id_fault, imem_addr); end
    step(1, 0, 0, 0);
    checks++; if (id_fault !== 1'b1 || imem_addr !== 32'h408 || id_pc !== 32'h408) begin errors++;
      $display("FAIL fault_second fault=%b addr=%h idpc=%h exp 1/408/408", id_fault, imem_addr, id_pc); end
    step(1, 0, 1, 32'h0000_03FC);
    step(1, 0, 0, 0);
    checks++; if (id_fault !== 1'b0 || id_inst !== mem[255]) begin errors++;
      $display("FAIL last_word fault=%b inst=%h exp 0/%h", id_fault, id_inst, mem[255]); end
  endtask

  task automatic test_wrap();
    step(1, 0, 1, 32'hFFFF_FFFF);
    step(1, 0, 0, 0);
    checks++; if (imem_addr !== 32'h0 || id_pc !== 32'h0 || id_fault !== 1'b1 || id_valid !== 1'b1) begin errors++;
      $display("FAIL pc_wrap addr=%h idpc=%h fault=%b v=%b exp 0/0/1/1", imem_addr, id_pc, id_fault, id_valid); end
  endtask

  task automatic test_random();
    logic f, b;
    logic [31:0] ba;
    for (int i = 0; i < 300; i++) begin
      f = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: ba = $urandom;
        1: ba = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: ba = 32'($urandom_range(0, 1100));
      endcase
      step(1, f, b, ba);
      checks++;
      if (imem_addr !== m_pc || id_pc !== m_id_pc || id_inst !== m_id_inst ||
          id_valid !== m_id_valid || id_fault !== m_id_fault || fetch_count !== m_cnt) begin
        errors++;
        $display("FAIL random cyc=%0d addr=%h/%h idpc=%h/%h inst=%h/%h v=%b/%b f=%b/%b cnt=%0d/%0d",
                 i, imem_addr, m_pc, id_pc, m_id_pc, id_inst, m_id_inst, id_valid, m_id_valid,
                 id_fault, m_id_fault, fetch_count, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0);
    step(0, 1, 1, 32'h0000_0200);
    checks++; if (imem_addr !== 32'h0 || id_valid !== 1'b0 || fetch_count !== 0) begin errors++;
      $display("FAIL reset_mid addr=%h v=%b cnt=%0d exp 0/0/0", imem_addr, id_valid, fetch_count); end
  endtask

  initial begin
    rst_n = 0; freeze = 0; branch_taken = 0; branch_addr = 0;
    m_pc = 0; m_id_pc = 0; m_id_inst = NOP; m_id_valid = 0; m_id_fault = 0; m_cnt = 0;
    mem[0] = 32'hE3A00014;
    for (int i = 1; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_startup();
    test_freeze();
    test_branch();
    test_branch_freeze();
    test_fault();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
